// File: rtl/inv_sbox_seq.sv
// Sequential AES inverse S-box: optional inverse affine, then a^254 by square-and-multiply.
// Define INV_SBOX_AFFINE_EN for full InvSubBytes; leave undefined for the plain GF(2^8) inverse.
module inv_sbox_seq (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [7:0] in_byte_i,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_byte_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExp  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Exponent 254 scanned MSB first; bit 0 clear means the last step is a pure square.
    localparam logic [7:0] ExpBits = 8'hFE;

`ifdef INV_SBOX_AFFINE_EN
    localparam logic [7:0] AffineC = 8'h05;
`endif

    logic [1:0] state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] r_q, r_d;
    logic [2:0] cnt_q, cnt_d;
    logic       out_valid_q, out_valid_d;

    logic [7:0] sq;
    logic [7:0] sq_mul_a;
    logic [7:0] affine_in;

    // Carry-less 8x8 product, then fold bits 14..8 back with x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                p = p ^ (15'(x) << i);
            end
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) begin
                p = p ^ (15'h011B << (k - 8));
            end
        end
        return p[7:0];
    endfunction

`ifdef INV_SBOX_AFFINE_EN
    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) begin
            b[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ AffineC[i];
        end
        return b;
    endfunction
`endif

    always_comb begin
        sq       = gf_mul(r_q, r_q);
        sq_mul_a = gf_mul(sq, a_q);
`ifdef INV_SBOX_AFFINE_EN
        affine_in = inv_affine(in_byte_i);
`else
        affine_in = in_byte_i;
`endif
    end

    assign in_ready_o  = (state_q == StIdle) && !rst_i;
    assign out_valid_o = out_valid_q;
    assign out_byte_o  = r_q;

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = affine_in;
                    r_d     = 8'h01;
                    cnt_d   = 3'd7;
                    state_d = StExp;
                end
            end
            StExp: begin
                r_d = ExpBits[cnt_q] ? sq_mul_a : sq;
                if (cnt_q == 3'd0) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            StDone: begin
                // Input is deliberately not looked at here; accept only happens from idle.
                if (out_ready_i) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            a_q         <= 8'h00;
            r_q         <= 8'h00;
            cnt_q       <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_inv_sbox_seq.sv
// Directed bench for inv_sbox_seq; expectations follow INV_SBOX_AFFINE_EN when defined.
module tb_inv_sbox_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;

    int n_checks = 0;
    int n_fail   = 0;

    inv_sbox_seq dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_byte_i   (in_byte),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_byte_o  (out_byte)
    );

    always #5 clk = ~clk;

    // Shift-and-add GF(2^8) multiply with xtime reduction.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_model(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] c8;
`ifdef INV_SBOX_AFFINE_EN
        t = ((x >> 2) | (x << 6)) ^ ((x >> 5) | (x << 3)) ^ ((x >> 7) | (x << 1)) ^ 8'h05;
`else
        t = x;
`endif
        if (t == 8'h00) return 8'h00;
        for (int c = 1; c < 256; c++) begin
            c8 = c[7:0];
            if (gmul(t, c8) == 8'h01) return c8;
        end
        return 8'h00;
    endfunction

    // Stimulus only: issue one byte from idle, return the first visible result and its latency.
    task automatic run_byte(input logic [7:0] x, output logic [7:0] y, output int lat);
        in_byte  = x;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        y   = 8'h00;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = i;
                y   = out_byte;
                break;
            end
        end
    endtask

    task automatic finish_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_byte   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if (out_byte !== 8'h00) begin
            n_fail++; $display("FAIL reset_out_byte got %h want 00", out_byte);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready_during_rst got %b want 0", in_ready);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready_after got %b want 1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        logic [7:0] vin [5];
        logic [7:0] vexp [5];
        logic [7:0] y;
        int lat;
`ifdef INV_SBOX_AFFINE_EN
        vin  = '{8'h63, 8'h7C, 8'h00, 8'hED, 8'h16};
        vexp = '{8'h00, 8'h01, 8'h52, 8'h53, 8'hFF};
`else
        vin  = '{8'h00, 8'h01, 8'h02, 8'h53, 8'hFF};
        vexp = '{8'h00, 8'h01, 8'h8D, 8'hCA, 8'h1C};
`endif
        for (int i = 0; i < 5; i++) begin
            run_byte(vin[i], y, lat);
            n_checks++;
            if (lat != 8) begin
                n_fail++; $display("FAIL vec_latency in=%h got %0d want 8", vin[i], lat);
            end
            n_checks++;
            if (y !== vexp[i]) begin
                n_fail++; $display("FAIL vec_value in=%h got %h want %h", vin[i], y, vexp[i]);
            end
            finish_out();
            n_checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL vec_return_idle got in_ready=%b out_valid=%b want 1/0",
                         in_ready, out_valid);
            end
        end
    endtask

    task automatic test_sweep();
        logic [7:0] x8;
        logic [7:0] y;
        int lat;
        for (int x = 0; x < 256; x++) begin
            x8 = x[7:0];
            run_byte(x8, y, lat);
            n_checks++;
`ifdef INV_SBOX_AFFINE_EN
            if (lat != 8 || y !== ref_model(x8)) begin
                n_fail++;
                $display("FAIL sweep in=%h got %h lat %0d want %h lat 8", x8, y, lat, ref_model(x8));
            end
`else
            if (lat != 8 || (x8 == 8'h00 ? (y !== 8'h00) : (gmul(x8, y) !== 8'h01))) begin
                n_fail++;
                $display("FAIL sweep in=%h got %h lat %0d (product %h) want product 01 lat 8",
                         x8, y, lat, gmul(x8, y));
            end
`endif
            finish_out();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] y;
        logic [7:0] want;
        int lat;
        int bad;
        bit seen;
        want = ref_model(8'h5A);
        run_byte(8'h5A, y, lat);
        n_checks++;
        if (lat != 8 || y !== want) begin
            n_fail++; $display("FAIL bp_first got %h lat %0d want %h lat 8", y, lat, want);
        end
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            in_valid = c[0];
            in_byte  = 8'hA0 + 8'(c);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_byte !== want || in_ready !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL bp_hold got %0d bad cycles want 0", bad);
        end
        // Output handshake and input valid in the same edge must not accept.
        in_valid  = 1'b1;
        in_byte   = 8'h33;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_byte !== want) begin
            n_fail++;
            $display("FAIL bp_no_accept_on_release got rdy=%b vld=%b byte=%h want 1/0/%h",
                     in_ready, out_valid, out_byte, want);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL bp_spurious_output got out_valid=1 want 0");
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] y;
        logic [7:0] x;
        int lat;
        bit seen;
`ifdef INV_SBOX_AFFINE_EN
        x = 8'h7C;
`else
        x = 8'h02;
`endif
        in_byte  = 8'hC3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_byte !== 8'h00 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_state got vld=%b byte=%h rdy=%b want 0/00/1",
                     out_valid, out_byte, in_ready);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++; $display("FAIL midrst_discard got out_valid=1 want 0");
        end
        run_byte(x, y, lat);
        n_checks++;
        if (lat != 8 || y !== ref_model(x)) begin
            n_fail++;
            $display("FAIL midrst_recover got %h lat %0d want %h lat 8", y, lat, ref_model(x));
        end
        finish_out();
    endtask

    task automatic test_streaming();
        logic [7:0] vec [16];
        int idx;
        int n_out;
        int last_acc;
        int bad_gap;
        int bad_val;
        bit fire_in;
        bit fire_out;
        vec = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h1F, 8'h53, 8'h63,
                8'h7C, 8'h80, 8'hA5, 8'hC3, 8'hED, 8'hF0, 8'h16, 8'hFF};
        idx      = 0;
        n_out    = 0;
        last_acc = -1;
        bad_gap  = 0;
        bad_val  = 0;
        in_byte   = vec[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && n_out < 16; cyc++) begin
            fire_in  = in_valid && in_ready;
            fire_out = out_valid && out_ready;
            if (fire_out) begin
                if (out_byte !== ref_model(vec[n_out])) begin
                    bad_val++;
                    $display("FAIL stream_value idx %0d got %h want %h",
                             n_out, out_byte, ref_model(vec[n_out]));
                end
                n_out++;
            end
            if (fire_in) begin
                if (last_acc >= 0 && cyc - last_acc != 10) bad_gap++;
                last_acc = cyc;
                idx++;
            end
            @(posedge clk); #1;
            if (fire_in) begin
                if (idx < 16) in_byte = vec[idx];
                else in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (n_out != 16 || idx != 16) begin
            n_fail++; $display("FAIL stream_count got out %0d in %0d want 16/16", n_out, idx);
        end
        n_checks++;
        if (bad_gap != 0) begin
            n_fail++; $display("FAIL stream_gap got %0d irregular accepts want 0", bad_gap);
        end
        n_checks++;
        if (bad_val != 0) begin
            n_fail++; $display("FAIL stream_values got %0d wrong want 0", bad_val);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_sweep();
        test_backpressure();
        test_reset_mid();
        test_streaming();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
